imem_server: RTL
================

# imem_server

Instruction-memory responder: the memory-side end of the fetch interface. It owns the instruction RAM, accepts word-fetch requests from the fetch stage, and returns instruction words in request order through a valid/ready handshake. A 2-entry response buffer absorbs fetch-side backpressure. After reset it holds a load phase in which an external loader writes the program image, then switches to serving fetches.

## Interface
- ADDR_WIDTH, riscv::IMEM_ADDR_WIDTH, word-index width of the RAM (depth = 2**ADDR_WIDTH words)
- DATA_WIDTH, riscv::IMEM_DATA_WIDTH, instruction word width (32)
- clk  in  1  clock; all state changes on the rising edge
- resetn  in  1  reset; synchronous, active-low
- req_valid  in  1  fetch request valid
- req_ready  out  1  request accepted on the edge when req_valid && req_ready
- req_addr  in  WORD_WIDTH  byte address (pc)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  fetch consumes the response when rsp_valid && rsp_ready
- rsp_data  out  DATA_WIDTH  instruction word (ir_t)
- rsp_err  out  1  request was misaligned or out of range
- flush  in  1  pc redirect; discard every outstanding response
- ld_valid  in  1  loader write strobe
- ld_ready  out  1  loader write accepted
- ld_addr  in  ADDR_WIDTH  word index to write
- ld_data  in  DATA_WIDTH  word to write
- ld_done  in  1  end of load; move to RUN

## Operation
- States: LOAD (after reset) and RUN. LOAD -> RUN on ld_done. RUN is left only by reset.
- LOAD: ld_ready=1, so every ld_valid cycle writes ld_data to RAM[ld_addr]. req_ready=0 and rsp_valid=0. If ld_valid and ld_done are both high in the same cycle, the write is performed, then the state changes.
- RUN: ld_ready=0 and loader writes are ignored.
- Index = req_addr[ADDR_WIDTH+1:2].
  - Misaligned: req_addr[1:0]!=0.
  - Out of range: any req_addr bit above ADDR_WIDTH+1 is set.
  - Either case: the request is still accepted and occupies one slot. The response has rsp_err=1 and rsp_data=32'h0000_0013 (NOP). The RAM content is not used.
- Occupancy = reads in flight + buffered responses, maximum 2.
  - req_ready = RUN && !flush && (occupancy < 2, or a response is consumed this cycle).
- Responses are returned strictly in request order and are never dropped, except by flush.
- Flush: in the flush cycle rsp_valid=0, req_ready=0, and no handshake occurs. The buffer is emptied and a read in flight is marked so that its data is discarded. Occupancy is 0 in the next cycle.
- Reset mid-operation: the state returns to LOAD and all responses are dropped. RAM contents are not reset and are kept.

## Timing
- Reset values (cycle after resetn low): req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, ld_ready=1 (state LOAD).
- Latency: request accepted at edge N -> rsp_valid=1 in cycle N+1 when the buffer is empty. The RAM output bypasses the buffer.
- Throughput: one request per cycle while rsp_ready stays high.
- Backpressure: with rsp_ready=0, at most 2 responses are held. rsp_valid, rsp_data and rsp_err stay stable until the handshake.
- Flush and request in the same cycle: the request is not accepted.
- LOAD -> RUN: ld_done at edge N -> req_ready may assert in cycle N+1. A fetch issued then sees every write made up to and including edge N.

## Structure
- Shared package (riscv): IMEM_ADDR_WIDTH, IMEM_DATA_WIDTH, WORD_WIDTH, NOP encoding constant. The rv32i package provides ir_t.
- State enum (LOAD, RUN) is local to this module.
- Sub-module: imem (synchronous single-port RAM, 1-cycle read, write enable, no reset). It is shared with the loader path through a port mux.
- The 2-entry response FIFO, holding {err, data} and a flush-drop flag, is inline logic.

## Test plan
- Load words 0x00500093, 0x00A00113, 0x002081B3 at indices 0-2, then ld_done. Fetch 0x0, 0x4, 0x8 back-to-back with rsp_ready=1 -> the three words appear in order on consecutive cycles, one cycle after each accept, with rsp_err=0.
- Backpressure: issue 4 requests, rsp_ready=0 for 3 cycles -> req_ready drops after 2 accepts. Releasing rsp_ready delivers all 4 in order with no loss or duplication.
- Errors: req_addr=0x2 -> rsp_err=1, data 0x00000013. req_addr=4<<ADDR_WIDTH -> rsp_err=1. A following aligned request returns correct data.
- Flush with 2 responses outstanding -> neither is delivered. The next request (0x4) returns RAM[1] one cycle after its accept.
- LOAD phase: req_valid held high before ld_done -> req_ready=0 and rsp_valid=0 throughout. ld_valid and ld_done in the same cycle -> that write is readable by the first fetch.
- Reset mid-run with 2 outstanding -> rsp_valid=0 and ld_ready=1 in the next cycle. After ld_done with no reloading, the old program words are still read back.

Source files
------------

// File: rtl/imem_server_pkg.sv
// Shared definitions for the instruction-memory responder.
//   IMEM_ADDR_WIDTH : word-index width of the instruction RAM
//   IMEM_DATA_WIDTH : instruction word width
//   WORD_WIDTH      : byte-address (pc) width of fetch requests
//   NOP             : instruction returned for rejected fetch addresses
//   ir_t / rsp_t    : instruction word and buffered {err, data} response
//   addr_bad()      : misaligned or out-of-range fetch address test
package imem_server_pkg;

  localparam int IMEM_ADDR_WIDTH = 8;
  localparam int IMEM_DATA_WIDTH = 32;
  localparam int WORD_WIDTH      = 32;
  localparam logic [IMEM_DATA_WIDTH-1:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef logic [IMEM_DATA_WIDTH-1:0] ir_t;

  typedef struct packed {
    logic err;
    ir_t  data;
  } rsp_t;

  // A fetch address is rejected when it is not word aligned or when any
  // byte-address bit above the RAM index is set.
  function automatic logic addr_bad(input logic [WORD_WIDTH-1:0] addr, input int aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
  endfunction

endpackage

// File: rtl/imem_server_if.sv
// Fetch-side request/response bus between the fetch stage and imem_server.
//   req_valid/req_ready/req_addr : word-fetch request, byte address
//   rsp_valid/rsp_ready          : response handshake
//   rsp_data/rsp_err             : instruction word and address-error flag
//   flush                        : pc redirect, discards outstanding responses
// master = fetch stage, slave = memory responder.
interface imem_server_if;
  import imem_server_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [WORD_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  ir_t                   rsp_data;
  logic                  rsp_err;
  logic                  flush;

  modport master (
    output req_valid, req_addr, rsp_ready, flush,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/imem.sv
// Synchronous single-port RAM with a one-cycle registered read.
//   clk   : clock
//   en    : port enable (read when we=0, write when we=1)
//   we    : write enable
//   addr  : word index
//   wdata : write data
//   rdata : read data, updated only by an enabled read
// No reset: contents and the read register survive a design reset.
module imem #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_server.sv
// Instruction-memory responder. Holds a LOAD phase after reset in which an
// external loader writes the program image, then serves in-order word
// fetches with up to two responses outstanding.
//   clk, resetn       : clock, synchronous active-low reset
//   bus (slave)       : fetch request/response bus with flush
//   ld_valid/ld_ready : loader write handshake (ready only in LOAD)
//   ld_addr, ld_data  : loader word index and data
//   ld_done           : end of program load, moves to RUN
module imem_server
  import imem_server_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = IMEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  imem_server_if.slave          bus,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_done
);

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic            rd_valid_q, rd_valid_d;   // RAM output holds a live response
  logic            rd_err_q, rd_err_d;
  rsp_t            rsp_buf_q [2];
  rsp_t            rsp_buf_d [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      count_q, count_d;

  logic                  run;
  logic                  req_fire, rsp_fire;
  logic                  push, pop;
  logic [1:0]            occupancy;
  rsp_t                  rd_view, head;
  logic                  ram_en, ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  imem #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_imem (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ld_data),
    .rdata (ram_rdata)
  );

  // Handshake outputs and RAM port mux.
  always_comb begin
    run          = (state_q == ST_RUN);
    occupancy    = {1'b0, rd_valid_q} + count_q;
    rd_view.err  = rd_err_q;
    rd_view.data = rd_err_q ? NOP : ram_rdata;
    // The RAM output bypasses the buffer only when nothing older is queued.
    head          = (count_q != 2'd0) ? rsp_buf_q[rd_ptr_q] : rd_view;
    bus.rsp_valid = run && !bus.flush && ((count_q != 2'd0) || rd_valid_q);
    bus.rsp_data  = bus.rsp_valid ? head.data : '0;
    bus.rsp_err   = bus.rsp_valid && head.err;
    rsp_fire      = bus.rsp_valid && bus.rsp_ready;
    bus.req_ready = run && !bus.flush && ((occupancy < 2'd2) || rsp_fire);
    req_fire      = bus.req_valid && bus.req_ready;
    ld_ready      = !run;
    ram_we        = !run && ld_valid;
    ram_en        = ram_we || req_fire;
    ram_addr      = run ? bus.req_addr[ADDR_WIDTH+1:2] : ld_addr;
  end

  // Next state: phase, read stage and response buffer.
  always_comb begin
    state_d    = state_q;
    rd_valid_d = req_fire;
    rd_err_d   = req_fire && addr_bad(bus.req_addr, ADDR_WIDTH);
    rsp_buf_d  = rsp_buf_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pop        = rsp_fire && (count_q != 2'd0);
    // The fresh RAM word is buffered unless it was consumed on the bypass
    // path; under flush it is simply never stored, which discards it.
    push       = rd_valid_q && !bus.flush && !(rsp_fire && (count_q == 2'd0));

    if (!run && ld_done) begin
      state_d = ST_RUN;
    end
    if (push) begin
      rsp_buf_d[wr_ptr_q] = rd_view;
      wr_ptr_d            = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
    if (bus.flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_LOAD;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer payload needs no reset; count_q qualifies every entry.
  always_ff @(posedge clk) begin
    rsp_buf_q <= rsp_buf_d;
  end

endmodule
